// File: rtl/pc_unit.sv
// Program counter and next-PC selector for the RV32I single-cycle core, with boot/halt/trap FSM.
// Optional instruction-retired counter is built when PC_INSTRET_EN is defined.
module pc_unit #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_0000,
   parameter logic [WIDTH-1:0] TRAP_VEC  = 32'h0000_0100
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall_i,
   input  logic             halt_i,
   input  logic [WIDTH-1:0] pc4_i,
   input  logic             branch_taken_i,
   input  logic [WIDTH-1:0] branch_target_i,
   input  logic             jump_i,
   input  logic [WIDTH-1:0] jump_target_i,
   output logic [WIDTH-1:0] pc_o,
   output logic [WIDTH-1:0] incr_o,
   output logic             pc_valid_o,
   output logic             trap_o,
   output logic [WIDTH-1:0] trap_pc_o,
   output logic [1:0]       state_o
`ifdef PC_INSTRET_EN
   ,output logic [63:0]     instret_o
`endif
);

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_RUN   = 2'd1,
      ST_TRAP  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_trap_pc;
   logic             r_pc_valid;
   logic             r_trap;

   logic [WIDTH-1:0] w_pc_next;
   logic [WIDTH-1:0] w_trap_pc_next;
   logic             w_pc_valid_next;
   logic             w_trap_next;
   logic             w_advance;

   logic             w_redirect;
   logic [WIDTH-1:0] w_target;
   logic             w_misaligned;

   // Jump outranks branch; only the redirect path is alignment-checked, never pc4_i.
   assign w_redirect   = jump_i | branch_taken_i;
   assign w_target     = jump_i ? jump_target_i : branch_target_i;
   assign w_misaligned = w_redirect && (w_target[1:0] != 2'b00);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_RESET;
      else        r_state <= w_state_next;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         ST_RESET: w_state_next = ST_RUN;
         ST_RUN: begin
            if (halt_i)                       w_state_next = ST_HALT;
            else if (!stall_i && w_misaligned) w_state_next = ST_TRAP;
         end
         ST_TRAP:  w_state_next = ST_RUN;
         ST_HALT:  w_state_next = ST_HALT;
         default:  w_state_next = ST_RESET;
      endcase
   end

   always_comb begin
      w_pc_next      = r_pc;
      w_trap_pc_next = r_trap_pc;
      w_advance      = 1'b0;
      unique case (r_state)
         ST_RUN: begin
            if (!halt_i && !stall_i) begin
               if (w_misaligned) begin
                  w_pc_next      = TRAP_VEC;
                  w_trap_pc_next = w_target;
               end else begin
                  w_pc_next = w_redirect ? w_target : pc4_i;
                  w_advance = 1'b1;
               end
            end
         end
         // The trap handler's first fetch happened during TRAP, so move on past it.
         ST_TRAP: w_pc_next = pc4_i;
         default: ;
      endcase
      w_pc_valid_next = (w_state_next == ST_RUN) || (w_state_next == ST_TRAP);
      w_trap_next     = (w_state_next == ST_TRAP);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc       <= RESET_VEC;
         r_trap_pc  <= '0;
         r_pc_valid <= 1'b0;
         r_trap     <= 1'b0;
      end else begin
         r_pc       <= w_pc_next;
         r_trap_pc  <= w_trap_pc_next;
         r_pc_valid <= w_pc_valid_next;
         r_trap     <= w_trap_next;
      end
   end

`ifdef PC_INSTRET_EN
   logic [63:0] r_instret;

   always_ff @(posedge clk) begin
      if (!rst_n)         r_instret <= '0;
      else if (w_advance) r_instret <= r_instret + 64'd1;
   end

   assign instret_o = r_instret;
`else
   logic w_unused_advance;
   assign w_unused_advance = w_advance;
`endif

   assign pc_o       = r_pc;
   assign incr_o     = WIDTH'(4);
   assign pc_valid_o = r_pc_valid;
   assign trap_o     = r_trap;
   assign trap_pc_o  = r_trap_pc;
   assign state_o    = r_state;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter register and next-PC selector for the RV32I single-cycle core.
- Holds the current fetch address and drives it to instruction memory and to the pc+4 adder.
- Consumes the adder's sum, plus the branch and jump targets from execute, and selects the next PC.
- Adds a small control FSM for boot, halt and misaligned-target trap handling.

Parameters:
- WIDTH, 32, address/PC width in bits.
- RESET_VEC, 32'h0000_0000, PC loaded on reset; first fetch address.
- TRAP_VEC, 32'h0000_0100, PC loaded when a misaligned redirect target is detected.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- stall_i  input  1  hold the PC this cycle.
- halt_i  input  1  stop fetching; enter HALT.
- pc4_i  input  WIDTH  pc_o + 4 from the pc+4 adder.
- branch_taken_i  input  1  conditional branch resolved taken.
- branch_target_i  input  WIDTH  branch destination.
- jump_i  input  1  JAL/JALR redirect.
- jump_target_i  input  WIDTH  jump destination.
- pc_o  output  WIDTH  current fetch address.
- incr_o  output  WIDTH  constant 4, driven to the adder's constant input.
- pc_valid_o  output  1  pc_o is a valid fetch address.
- trap_o  output  1  one-cycle pulse on a misaligned redirect.
- trap_pc_o  output  WIDTH  offending target captured at the last trap.
- state_o  output  2  FSM state: 0 RESET, 1 RUN, 2 TRAP, 3 HALT.

Behaviour:
- Reset: rst_n is synchronous and active-low. When rst_n==0 at a rising edge:
  - pc_o=RESET_VEC, pc_valid_o=0, trap_o=0, trap_pc_o=0, state=RESET.
  - Reset overrides every other input, including mid-operation and mid-halt.
- incr_o is the constant 4 at all times. It is combinational and unaffected by reset.
- RESET: on the first edge with rst_n==1, go to RUN with pc_valid_o=1. pc_o stays at RESET_VEC, so the first fetch is at RESET_VEC. No other input is sampled in RESET.
- RUN: next-PC priority, evaluated per edge:
  1. halt_i=1 → HALT; pc_o held; pc_valid_o=0.
  2. stall_i=1 → pc_o held. Redirects and pc4_i are ignored; the producer must hold any redirect until the stall clears.
  3. jump_i=1 → candidate = jump_target_i.
  4. branch_taken_i=1 → candidate = branch_target_i.
  5. otherwise → pc_o <= pc4_i.
- Jump and branch asserted together: the jump wins.
- Misaligned redirect: if the selected redirect candidate has bits[1:0]!=0:
  - pc_o <= TRAP_VEC, trap_pc_o <= candidate, trap_o=1 for exactly one cycle, state → TRAP.
  - The pc4_i path is never alignment-checked.
- TRAP: lasts one cycle with pc_valid_o=1 and trap_o=1, then returns to RUN unconditionally. A stall arriving while in TRAP is honoured on the following RUN cycle.
- HALT: pc_o frozen, pc_valid_o=0, all inputs ignored. The only exit is reset.
- Arithmetic: no internal adder. A pc4_i wrap from 0xFFFF_FFFC to 0x0000_0000 is accepted without a trap.
- All outputs are registered except incr_o. Redirect latency is one cycle: a target presented in cycle N appears on pc_o in cycle N+1.

Optional Feature:
- Macro: PC_INSTRET_EN.
- When defined:
  - Adds output instret_o [63:0]. It increments on every edge where the FSM is in RUN and pc_o is updated by pc4_i, branch or jump without a trap.
  - It does not increment on stall, trap, halt or RESET cycles.
  - Reset value 0; wraps modulo 2^64.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then release, no stall, adder model feeding pc4_i: pc_o sequence 0x0, 0x0, 0x4, 0x8, 0xC; pc_valid_o rises on the first edge after release; state_o 0→1.
- In RUN at pc 0x10, jump_i=1 with target 0x40 and branch_taken_i=1 with target 0x80 in the same cycle: next pc_o=0x40. Then branch only with target 0x80: pc_o=0x80.
- stall_i held for 3 cycles at pc 0x20 with jump_i=1 to 0x60 during the stall, then stall released with the jump held: pc_o stays 0x20 for 3 cycles, then becomes 0x60.
- jump_target_i=0x42: pc_o=0x100, trap_o high for exactly 1 cycle, trap_pc_o=0x42, state_o 1→2→1; the next pc_o comes from pc4_i (0x104).
- halt_i=1 at pc 0x30: pc_o frozen at 0x30, pc_valid_o=0, state_o=3; jump and stall inputs are ignored. rst_n=0 for one edge: pc_o=0x0, state_o=0.
- With PC_INSTRET_EN: 10 sequential instructions, 2 stall cycles and 1 misaligned trap give instret_o=10 after the run.
